// File: rtl/dnn_output_evaluator_pkg.sv
// -----------------------------------------------------------------------------
// dnn_eval_pkg
// Shared constants and helpers for the DNN output evaluator.
//   TOTAL_W  : width of the committed-sample counter.
//   POP_W    : maximum vector width accepted by popcount().
//   cnt_w()  : width of a counter that must hold 0..win inclusive.
//   popcount : number of set bits, used for the one-hot label check.
// -----------------------------------------------------------------------------
package dnn_eval_pkg;

  localparam int TOTAL_W = 32;
  localparam int POP_W   = 64;

  function automatic int cnt_w(input int w);
    return $clog2(w + 32'sd1);
  endfunction

  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned c;
    c = 32'd0;
    for (int i = 0; i < POP_W; i++) begin
      c = c + {31'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/dnn_output_evaluator_if.sv
// -----------------------------------------------------------------------------
// dnn_output_evaluator_if
// Bundle between the DNN output stage / harness (master) and the evaluator
// (slave).
//   cycle_index    : position inside the current cycle block
//   a_out, y_out   : actual / ideal output slice for this clock
//   sample_valid   : verdict committed (1-clock pulse)
//   sample_correct : verdict of the last committed sample
//   label_err      : committed sample had a non-one-hot ideal label (pulse)
//   correct_count  : correct samples so far in the open window
//   window_correct : correct samples of the last completed window
//   window_done    : window completed (pulse, aligned with sample_valid)
//   total_samples  : committed samples since reset, saturating
//   best_window    : best window score seen (only with EVAL_BESTWIN_EN)
// Optional feature macro: EVAL_BESTWIN_EN
// -----------------------------------------------------------------------------
interface dnn_output_evaluator_if
  import dnn_eval_pkg::*;
#(
  parameter int cpc = 6,
  parameter int zo  = 1,
  parameter int win = 8
);

  localparam int IDX_W = $clog2(cpc);
  localparam int CW    = cnt_w(win);

  logic [IDX_W-1:0]   cycle_index;
  logic [zo-1:0]      a_out;
  logic [zo-1:0]      y_out;
  logic               sample_valid;
  logic               sample_correct;
  logic               label_err;
  logic [CW-1:0]      correct_count;
  logic [CW-1:0]      window_correct;
  logic               window_done;
  logic [TOTAL_W-1:0] total_samples;
`ifdef EVAL_BESTWIN_EN
  logic [CW-1:0]      best_window;

  modport master (
    output cycle_index, a_out, y_out,
    input  sample_valid, sample_correct, label_err, correct_count,
           window_correct, window_done, total_samples, best_window
  );

  modport slave (
    input  cycle_index, a_out, y_out,
    output sample_valid, sample_correct, label_err, correct_count,
           window_correct, window_done, total_samples, best_window
  );
`else
  modport master (
    output cycle_index, a_out, y_out,
    input  sample_valid, sample_correct, label_err, correct_count,
           window_correct, window_done, total_samples
  );

  modport slave (
    input  cycle_index, a_out, y_out,
    output sample_valid, sample_correct, label_err, correct_count,
           window_correct, window_done, total_samples
  );
`endif

endinterface

// File: rtl/dnn_eval_window_counter.sv
// -----------------------------------------------------------------------------
// dnn_eval_window_counter
// Counts committed samples into fixed windows of `win` samples.
//   clk, reset       : clock, synchronous active-high reset
//   commit_i         : a sample verdict is being committed this clock
//   correct_i        : that verdict is "correct"
//   correct_count_o  : correct samples in the open window (registered)
//   window_correct_o : score of the last completed window (registered)
//   window_done_o    : pulse when the win-th sample of a window commits
//   best_window_o    : best window score so far (only with EVAL_BESTWIN_EN)
// All outputs update on the same edge as the top's sample_valid register.
// -----------------------------------------------------------------------------
module dnn_eval_window_counter
  import dnn_eval_pkg::*;
#(
  parameter  int win = 8,
  localparam int CW  = cnt_w(win)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          commit_i,
  input  logic          correct_i,
  output logic [CW-1:0] correct_count_o,
  output logic [CW-1:0] window_correct_o,
`ifdef EVAL_BESTWIN_EN
  output logic [CW-1:0] best_window_o,
`endif
  output logic          window_done_o
);

  logic [CW-1:0] cnt_q,  cnt_d;
  logic [CW-1:0] samp_q, samp_d;
  logic [CW-1:0] wcorr_q, wcorr_d;
  logic          done_q, done_d;
  logic [CW-1:0] new_cnt_s;
`ifdef EVAL_BESTWIN_EN
  logic [CW-1:0] best_q, best_d;
`endif

  // Next-state for the window sample counter, correct counter and done pulse.
  always_comb begin
    cnt_d     = cnt_q;
    samp_d    = samp_q;
    wcorr_d   = wcorr_q;
    done_d    = 1'b0;
`ifdef EVAL_BESTWIN_EN
    best_d    = best_q;
`endif
    // Score including the sample being committed; never exceeds win.
    new_cnt_s = cnt_q + CW'(correct_i);
    if (commit_i) begin
      if (samp_q == CW'(win - 1)) begin
        wcorr_d = new_cnt_s;
        done_d  = 1'b1;
        cnt_d   = {CW{1'b0}};
        samp_d  = {CW{1'b0}};
`ifdef EVAL_BESTWIN_EN
        if (new_cnt_s > best_q) begin
          best_d = new_cnt_s;
        end else begin
          best_d = best_q;
        end
`endif
      end else begin
        cnt_d  = new_cnt_s;
        samp_d = samp_q + CW'(1);
      end
    end else begin
      cnt_d  = cnt_q;
      samp_d = samp_q;
    end
  end

  // Window state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= {CW{1'b0}};
      samp_q  <= {CW{1'b0}};
      wcorr_q <= {CW{1'b0}};
      done_q  <= 1'b0;
`ifdef EVAL_BESTWIN_EN
      best_q  <= {CW{1'b0}};
`endif
    end else begin
      cnt_q   <= cnt_d;
      samp_q  <= samp_d;
      wcorr_q <= wcorr_d;
      done_q  <= done_d;
`ifdef EVAL_BESTWIN_EN
      best_q  <= best_d;
`endif
    end
  end

  assign correct_count_o  = cnt_q;
  assign window_correct_o = wcorr_q;
  assign window_done_o    = done_q;
`ifdef EVAL_BESTWIN_EN
  assign best_window_o    = best_q;
`endif

endmodule

// File: rtl/dnn_output_evaluator.sv
// -----------------------------------------------------------------------------
// dnn_output_evaluator
// Reassembles the serial actual (a_out) and ideal (y_out) output slices of a
// DNN sample, judges the classification at the end of each cycle block and
// accumulates correct/total counts over fixed windows.
//   clk   : system clock
//   reset : synchronous, active-high; also discards a partially captured sample
//   bus   : dnn_output_evaluator_if.slave (cycle_index, a_out, y_out in;
//           verdict, window and total counters out, all registered)
// Parameters: cpc (clocks per block), p (output neurons), zo (neurons per
// clock), warmup (blocks discarded after reset), win (samples per window).
// Optional feature macro: EVAL_BESTWIN_EN adds bus.best_window.
// -----------------------------------------------------------------------------
module dnn_output_evaluator
  import dnn_eval_pkg::*;
#(
  parameter int cpc    = 6,
  parameter int p      = 4,
  parameter int zo     = 1,
  parameter int warmup = 2,
  parameter int win    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  dnn_output_evaluator_if.slave bus
);

  localparam int IDX_W  = $clog2(cpc);
  localparam int SLOTS  = p / zo;
  localparam int WARM_W = (warmup > 0) ? $clog2(warmup + 1) : 1;

  // Elaboration-time parameter sanity checks.
  generate
    if (cpc < SLOTS + 1) begin : g_chk_cpc
      $error("dnn_output_evaluator: cpc must be >= p/zo + 1");
    end
    if ((p % zo) != 0) begin : g_chk_zo
      $error("dnn_output_evaluator: p must be a multiple of zo");
    end
    if (win < 1) begin : g_chk_win
      $error("dnn_output_evaluator: win must be >= 1");
    end
    if (p > POP_W) begin : g_chk_p
      $error("dnn_output_evaluator: p exceeds popcount width");
    end
  endgenerate

  logic [p-1:0]       a_reg_q, a_reg_d;
  logic [p-1:0]       y_reg_q, y_reg_d;
  logic [WARM_W-1:0]  warm_q, warm_d;
  logic               valid_q, valid_d;
  logic               correct_q, correct_d;
  logic               lerr_q, lerr_d;
  logic [TOTAL_W-1:0] total_q, total_d;

  logic               block_end_s;
  logic               commit_s;
  logic               match_s;
  logic               onehot_s;
  logic               verdict_s;

  // Slice capture: slot k of the block lands in bits [k*zo +: zo].
  always_comb begin
    a_reg_d = a_reg_q;
    y_reg_d = y_reg_q;
    for (int s = 0; s < SLOTS; s++) begin
      if (bus.cycle_index == IDX_W'(s)) begin
        a_reg_d[s*zo +: zo] = bus.a_out;
        y_reg_d[s*zo +: zo] = bus.y_out;
      end else begin
        a_reg_d[s*zo +: zo] = a_reg_q[s*zo +: zo];
        y_reg_d[s*zo +: zo] = y_reg_q[s*zo +: zo];
      end
    end
  end

  // Block end is recognised by value only; out-of-sequence indices are not policed.
  always_comb begin
    block_end_s = (bus.cycle_index == IDX_W'(cpc - 1));
    commit_s    = block_end_s && (warm_q >= WARM_W'(warmup));
    match_s     = (a_reg_q == y_reg_q);
    onehot_s    = (popcount(POP_W'(y_reg_q)) == 32'd1);
    verdict_s   = match_s & onehot_s;
  end

  // Warmup, verdict and total-sample next-state.
  always_comb begin
    warm_d    = warm_q;
    valid_d   = 1'b0;
    correct_d = correct_q;
    lerr_d    = 1'b0;
    total_d   = total_q;
    if (block_end_s && (warm_q < WARM_W'(warmup))) begin
      warm_d = warm_q + WARM_W'(1);
    end else begin
      warm_d = warm_q;
    end
    if (commit_s) begin
      valid_d   = 1'b1;
      correct_d = verdict_s;
      lerr_d    = ~onehot_s;
      if (total_q == {TOTAL_W{1'b1}}) begin
        total_d = total_q;
      end else begin
        total_d = total_q + TOTAL_W'(1);
      end
    end else begin
      correct_d = correct_q;
      total_d   = total_q;
    end
  end

  // Capture buffers and verdict registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg_q   <= {p{1'b0}};
      y_reg_q   <= {p{1'b0}};
      warm_q    <= {WARM_W{1'b0}};
      valid_q   <= 1'b0;
      correct_q <= 1'b0;
      lerr_q    <= 1'b0;
      total_q   <= {TOTAL_W{1'b0}};
    end else begin
      a_reg_q   <= a_reg_d;
      y_reg_q   <= y_reg_d;
      warm_q    <= warm_d;
      valid_q   <= valid_d;
      correct_q <= correct_d;
      lerr_q    <= lerr_d;
      total_q   <= total_d;
    end
  end

  dnn_eval_window_counter #(
    .win (win)
  ) u_window (
    .clk              (clk),
    .reset            (reset),
    .commit_i         (commit_s),
    .correct_i        (verdict_s),
    .correct_count_o  (bus.correct_count),
    .window_correct_o (bus.window_correct),
`ifdef EVAL_BESTWIN_EN
    .best_window_o    (bus.best_window),
`endif
    .window_done_o    (bus.window_done)
  );

  assign bus.sample_valid   = valid_q;
  assign bus.sample_correct = correct_q;
  assign bus.label_err      = lerr_q;
  assign bus.total_samples  = total_q;

endmodule

// File: tb/tb_dnn_output_evaluator.sv
// -----------------------------------------------------------------------------
// tb_dnn_output_evaluator
// Directed, table-driven and randomized stimulus for dnn_output_evaluator.
// A sample-level reference model (assembled words, verdict history queue)
// predicts every output after every clock.
// -----------------------------------------------------------------------------
module tb_dnn_output_evaluator;
  import dnn_eval_pkg::*;

  localparam int CPC    = 6;
  localparam int P      = 4;
  localparam int ZO     = 1;
  localparam int WARMUP = 2;
  localparam int WIN    = 8;
  localparam int SLOTS  = P / ZO;
  localparam int IDX_W  = $clog2(CPC);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dnn_output_evaluator_if #(.cpc(CPC), .zo(ZO), .win(WIN)) bus ();

  dnn_output_evaluator #(
    .cpc(CPC), .p(P), .zo(ZO), .warmup(WARMUP), .win(WIN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [P-1:0] m_a, m_y;
  int           m_warm;
  bit           m_valid, m_correct, m_label, m_done;
  int           m_cc, m_wc, m_best, m_seen;
  longint       m_total;
  bit           m_hist[$];

  typedef struct {
    logic [P-1:0] a;
    logic [P-1:0] y;
    bit           exp_correct;
    bit           exp_label;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_a = '0; m_y = '0; m_warm = 0;
    m_valid = 0; m_correct = 0; m_label = 0; m_done = 0;
    m_cc = 0; m_wc = 0; m_best = 0; m_seen = 0; m_total = 0;
    m_hist.delete();
  endtask

  // Effect of one clock edge on the sample-level model.
  task automatic model_edge(input int idx, input logic [ZO-1:0] a_s,
                            input logic [ZO-1:0] y_s, input bit rst);
    bit ok;
    int pos, n, s;
    if (rst) begin
      model_reset();
      return;
    end
    m_valid = 0; m_label = 0; m_done = 0;
    if (idx == CPC - 1) begin
      if (m_warm < WARMUP) begin
        m_warm++;
      end else begin
        ok = (m_a == m_y) && ($countones(m_y) == 1);
        m_correct = ok;
        m_label = ($countones(m_y) != 1);
        m_valid = 1;
        if (m_total < 64'hFFFF_FFFF) m_total++;
        m_hist.push_back(ok);
        m_seen++;
        pos = m_seen % WIN;
        n = (pos == 0) ? WIN : pos;
        s = 0;
        for (int k = 0; k < n; k++) s += m_hist[m_hist.size() - 1 - k];
        if (pos == 0) begin
          m_wc = s; m_done = 1; m_cc = 0;
          if (s > m_best) m_best = s;
        end else begin
          m_cc = s;
        end
      end
    end
    if (idx < SLOTS) begin
      m_a[idx*ZO +: ZO] = a_s;
      m_y[idx*ZO +: ZO] = y_s;
    end
  endtask

  task automatic compare_all();
    check("sample_valid",   bus.sample_valid,   m_valid);
    check("sample_correct", bus.sample_correct, m_correct);
    check("label_err",      bus.label_err,      m_label);
    check("correct_count",  bus.correct_count,  m_cc);
    check("window_correct", bus.window_correct, m_wc);
    check("window_done",    bus.window_done,    m_done);
    check("total_samples",  bus.total_samples,  m_total);
`ifdef EVAL_BESTWIN_EN
    check("best_window",    bus.best_window,    m_best);
`endif
  endtask

  task automatic run_cycle(input int idx, input logic [P-1:0] a_w,
                           input logic [P-1:0] y_w, input bit rst);
    logic [ZO-1:0] a_s, y_s;
    @(negedge clk);
    if (idx < SLOTS) begin
      a_s = a_w[idx*ZO +: ZO];
      y_s = y_w[idx*ZO +: ZO];
    end else begin
      a_s = ZO'($urandom);
      y_s = ZO'($urandom);
    end
    reset = rst;
    bus.cycle_index = IDX_W'(idx);
    bus.a_out = a_s;
    bus.y_out = y_s;
    model_edge(idx, a_s, y_s, rst);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic run_block(input logic [P-1:0] a_w, input logic [P-1:0] y_w);
    for (int i = 0; i < CPC; i++) run_cycle(i, a_w, y_w, 1'b0);
  endtask

  task automatic run_window(input int ncorrect);
    for (int k = 0; k < WIN; k++) begin
      if (k < ncorrect) run_block(4'b0001, 4'b0001);
      else              run_block(4'b0010, 4'b0001);
    end
  endtask

  initial begin
    logic [P-1:0] ra, ry;
    reset = 1'b1;
    bus.cycle_index = '0;
    bus.a_out = '0;
    bus.y_out = '0;
    model_reset();

    vecs[0] = '{4'b0001, 4'b0001, 1'b1, 1'b0};
    vecs[1] = '{4'b0010, 4'b0001, 1'b0, 1'b0};
    vecs[2] = '{4'b0011, 4'b0011, 1'b0, 1'b1};
    vecs[3] = '{4'b0000, 4'b0000, 1'b0, 1'b1};
    vecs[4] = '{4'b1000, 4'b1000, 1'b1, 1'b0};
    vecs[5] = '{4'b1111, 4'b1111, 1'b0, 1'b1};
    vecs[6] = '{4'b0100, 4'b0100, 1'b1, 1'b0};
    vecs[7] = '{4'b0100, 4'b1000, 1'b0, 1'b0};

    // Reset held for three blocks with random data: outputs stay zero.
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < CPC; i++)
        run_cycle(i, P'($urandom), P'($urandom), 1'b1);
    check("reset_total", bus.total_samples, 64'd0);

    // Two warmup blocks, then the first verdict at the end of the third.
    run_block(4'b0001, 4'b0001);
    check("warmup1_no_valid", bus.sample_valid, 64'd0);
    run_block(4'b0001, 4'b0001);
    check("warmup2_no_valid", bus.sample_valid, 64'd0);
    run_block(4'b0001, 4'b0001);
    check("first_valid", bus.sample_valid, 64'd1);
    check("first_correct", bus.sample_correct, 64'd1);

    // Perfect-match window: eight correct samples.
    for (int b = 0; b < 7; b++) run_block(4'b0001, 4'b0001);
    check("perfect_done", bus.window_done, 64'd1);
    check("perfect_wc", bus.window_correct, 64'd8);
    check("perfect_cc", bus.correct_count, 64'd0);

    // One mismatch in the next window.
    run_block(4'b0010, 4'b0001);
    check("mismatch_correct", bus.sample_correct, 64'd0);
    for (int b = 0; b < 7; b++) run_block(4'b0001, 4'b0001);
    check("mismatch_wc", bus.window_correct, 64'd7);

    // Table-driven verdict vectors, exactly one window long.
    for (int v = 0; v < 8; v++) begin
      run_block(vecs[v].a, vecs[v].y);
      check("vec_valid", bus.sample_valid, 64'd1);
      check("vec_correct", bus.sample_correct, 64'(vecs[v].exp_correct));
      check("vec_label_err", bus.label_err, 64'(vecs[v].exp_label));
    end
    check("vec_wc", bus.window_correct, 64'd3);
    check("vec_total", bus.total_samples, 64'd24);

    // Label error lasts a single clock.
    run_block(4'b0011, 4'b0011);
    check("lerr_pulse", bus.label_err, 64'd1);
    run_cycle(0, 4'b0001, 4'b0001, 1'b0);
    check("lerr_gone", bus.label_err, 64'd0);
    for (int i = 1; i < CPC; i++) run_cycle(i, 4'b0001, 4'b0001, 1'b0);

    // Reset in the middle of a block discards it and restarts warmup.
    run_cycle(0, 4'b0001, 4'b0001, 1'b0);
    run_cycle(1, 4'b0001, 4'b0001, 1'b0);
    run_cycle(2, 4'b0001, 4'b0001, 1'b1);
    for (int i = 3; i < CPC; i++) run_cycle(i, 4'b0001, 4'b0001, 1'b0);
    check("midrst_total", bus.total_samples, 64'd0);
    check("midrst_no_valid", bus.sample_valid, 64'd0);
    run_block(4'b0001, 4'b0001);
    check("midrst_warm_no_valid", bus.sample_valid, 64'd0);

    // Windows scoring 5, 8, 6.
    run_window(5);
    check("win5", bus.window_correct, 64'd5);
`ifdef EVAL_BESTWIN_EN
    check("best_after5", bus.best_window, 64'd5);
`endif
    run_window(8);
    check("win8", bus.window_correct, 64'd8);
`ifdef EVAL_BESTWIN_EN
    check("best_after8", bus.best_window, 64'd8);
`endif
    run_window(6);
    check("win6", bus.window_correct, 64'd6);
`ifdef EVAL_BESTWIN_EN
    check("best_after6", bus.best_window, 64'd8);
`endif

    // Randomized blocks with occasional resets, checked against the model.
    for (int b = 0; b < 60; b++) begin
      if ($urandom_range(0, 1) == 0) ry = P'(1) << $urandom_range(0, P - 1);
      else                           ry = P'($urandom);
      if ($urandom_range(0, 3) != 0) ra = ry;
      else                           ra = P'($urandom);
      for (int i = 0; i < CPC; i++)
        run_cycle(i, ra, ry, ($urandom_range(0, 59) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dnn_output_evaluator.md
Name: dnn_output_evaluator

Overview:
- Sits directly downstream of the top-level DNN and consumes its serial actual-output stream (a_out) and ideal-output stream (y_out).
- Each cycle block carries one sample. The block reassembles the per-clock output slices of that sample, decides whether the network classified it correctly, and accumulates correct/total counts over fixed windows.
- Results are read by the test harness and a future on-chip accuracy monitor. The block does no arithmetic on activations; it only compares and counts.

Parameters:
- cpc, 6, clocks per cycle block; must equal the DNN's cpc. The block checks cpc >= p/zo + 1 at elaboration.
- p, 4, number of output neurons (n[L-1]).
- zo, 1, output neurons presented per clock (z[L-2]/fi[L-2]); p must be a multiple of zo.
- warmup, 2, number of initial cycle blocks discarded after reset (pipeline fill; equals L-1).
- win, 8, samples per accuracy window; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- cycle_index  in  $clog2(cpc)  cycle position from the shared cycle_block_counter.
- a_out  in  zo  actual output slice from the DNN.
- y_out  in  zo  ideal output slice from the DNN.
- sample_valid  out  1  one-clock pulse when a sample verdict is committed.
- sample_correct  out  1  verdict of the last committed sample.
- label_err  out  1  one-clock pulse alongside sample_valid if the sample's y_out was not one-hot.
- correct_count  out  $clog2(win+1)  running correct count in the current window.
- window_correct  out  $clog2(win+1)  correct count of the last completed window.
- window_done  out  1  one-clock pulse when a window completes.
- total_samples  out  32  committed samples since reset, saturating at 2^32-1.

Behaviour:
- Reset:
  - All outputs are 0.
  - Internal slice buffers, the warmup counter and the window counter are 0.
  - A reset asserted mid-block discards the partial sample.
- Capture:
  - When cycle_index < p/zo, a_out and y_out are stored into slice cycle_index of two p-bit registers (bits [cycle_index*zo +: zo]).
  - Slots p/zo..cpc-1 are ignored.
- Commit: on the clock where cycle_index == cpc-1 (block end), with registered outputs visible the next clock:
  - If the warmup count is < warmup: increment the warmup count, no pulse.
  - Otherwise:
    - match = (a_reg == y_reg).
    - onehot = (popcount(y_reg) == 1).
    - sample_correct <= match & onehot.
    - label_err pulses if !onehot.
    - sample_valid pulses.
    - total_samples increments (saturating).
    - correct_count increments if correct.
- Window: when the committed sample is the win-th of the window:
  - window_correct <= final count, including the current sample.
  - window_done pulses in the same clock as sample_valid.
  - correct_count and the window sample counter clear to 0.
- Latency: verdict registered 1 clock after the block-end index.
- Slot buffers are overwritten each block; no clear is needed between samples.
- cycle_index jumping out of sequence is not checked; the block end is detected only by value.

Optional Feature:
- EVAL_BESTWIN_EN:
  - When defined, adds output best_window (width $clog2(win+1), reset 0).
  - On each window_done, best_window <= max(best_window, new window_correct).
  - When undefined, the port and its register are absent.

Decomposition:
- Package dnn_eval_pkg holds:
  - localparam function cnt_w(win) = $clog2(win+1).
  - The 32-bit total width constant.
  - A popcount function used for the one-hot check.
- One natural sub-module: dnn_eval_window_counter, containing the window sample counter, correct counter and done pulse, which the top instantiates.

Test Plan:
- Reset hold: reset high for 3 blocks with random inputs -> all outputs 0 throughout; after release, first sample_valid at the end of the 3rd block (warmup=2).
- Perfect match: y_out slices 1,0,0,0 and a_out identical for 8 post-warmup blocks -> 8 sample_valid pulses, each with sample_correct=1; window_done with window_correct=8; correct_count back to 0.
- Mismatch: in one block a_out=0,1,0,0 against y_out=1,0,0,0 -> sample_correct=0; window_correct=7.
- Bad label: y_out=1,1,0,0 with a_out equal to it -> sample_correct=0 and label_err pulses for 1 clock.
- Mid-block reset: reset asserted at cycle_index=2 -> no commit for that block, warmup restarts, total_samples=0.
- EVAL_BESTWIN_EN: windows scoring 5, 8, 6 -> best_window reads 5, then 8, then stays 8.
